// File: rtl/fifo_pop_stage.sv
// fifo_pop_stage: pop-side reader for fifo_basic.
// Pops the FIFO (no backpressure on that side) into a two-entry registered
// skid stage and presents the words downstream on a valid/ready interface.
// fifo_pop is derived only from registered state, fifo_empty_r, flush and rst,
// so out_rdy has no combinational path to the FIFO.
//
// Handshake: a beat transfers in any cycle where out_vld & out_rdy (acc).
// Once out_vld is high, out_vld and out_data hold until acc; only flush or
// rst may withdraw a presented word.
module fifo_pop_stage #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty_r,
  input  logic [W-1:0]  fifo_pop_data,
  output logic          fifo_pop,
  input  logic          flush,
  output logic          out_vld,
  output logic [W-1:0]  out_data,
  input  logic          out_rdy,
  output logic          busy,
  output logic [CW-1:0] fwd_cnt_r,
  output logic [1:0]    dbg_state_o
);

  // Occupancy of the skid stage: head only, or head plus an older-than-FIFO skid word.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  skid_q, skid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc;

  // Output decode from registered state; pop is held low during reset.
  always_comb begin
    out_vld     = (state_q != ST_EMPTY);
    busy        = out_vld;
    out_data    = head_q;
    acc         = out_vld & out_rdy;
    fifo_pop    = !rst & !fifo_empty_r & !flush & (state_q != ST_TWO);
    dbg_state_o = state_q;
  end

  // Next-state, data steering and beat counting; flush overrides everything
  // except the count of a beat accepted in the flush cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + {{(CW-1){1'b0}}, acc};
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fifo_pop) begin
            state_d = ST_ONE;
            head_d  = fifo_pop_data;
          end
        end
        ST_ONE: begin
          if (fifo_pop && !acc) begin
            state_d = ST_TWO;
            skid_d  = fifo_pop_data;
          end else if (fifo_pop && acc) begin
            head_d  = fifo_pop_data;
          end else if (acc) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // The skid word is older than anything still in the FIFO.
          if (acc) begin
            state_d = ST_ONE;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, data and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_cnt_r = cnt_q;

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_pop && fifo_empty_r));

  a_no_pop_in_two: assert property (@(posedge clk) disable iff (rst)
    !(fifo_pop && (state_q == ST_TWO)));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_vld && !out_rdy && !flush) |=> (out_vld && $stable(out_data)));

endmodule
